// File: rtl/axi_rd_resp_back_end.sv
// AXI read-response back end.
// Buffers whole read-response packets from the OCP front end in a small FIFO and
// replays each one beat-by-beat on the AXI R channel. hold_out throttles the
// front end before the FIFO can overflow; a dropped packet sets overflow_err.
module axi_rd_resp_back_end #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_MARGIN = 1,
    parameter int unsigned ID_W        = 4,
    parameter int unsigned DATA_W      = 32,
    localparam int unsigned PKT_W      = ID_W + 4 + 16 * DATA_W,
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ocp_rd_resp_pkt_vld,
    input  logic [PKT_W-1:0]  ocp_rd_resp_pkt,
    output logic              hold_out,
    output logic              rvalid,
    input  logic              rready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              overflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                       state_q, state_d;
    logic [3:0]                   beat_q, beat_d;
    logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]             count_q;
    logic                         overflow_q;
    logic [PKT_W-1:0]             mem [DEPTH];

    logic [PKT_W-1:0]             head;
    logic [15:0][DATA_W-1:0]      head_beats;
    logic [3:0]                   head_len;
    logic [ID_W-1:0]              head_id;
    logic                         send;
    logic                         handshake;
    logic                         last_beat;
    logic                         pop;
    logic                         full;
    logic                         wr_en;

    // Head-of-queue packet fields; the head entry is never overwritten while it is displayed.
    assign head       = mem[rd_ptr_q];
    assign head_beats = head[16*DATA_W-1:0];
    assign head_len   = head[16*DATA_W +: 4];
    assign head_id    = head[16*DATA_W+4 +: ID_W];

    assign send      = (state_q == StSend);
    assign handshake = send && rready;
    assign last_beat = (beat_q == head_len);
    assign pop       = handshake && last_beat;
    assign full      = (count_q == CNT_W'(DEPTH));
    // A full FIFO still accepts a packet when the head leaves on the same edge.
    assign wr_en     = ocp_rd_resp_pkt_vld && (!full || pop);

    // Outputs depend only on registered state, never on rready; zero while idle.
    assign rvalid       = send;
    assign rid          = send ? head_id : '0;
    assign rdata        = send ? head_beats[beat_q] : '0;
    assign rlast        = send && last_beat;
    assign rresp        = 2'b00;
    assign pkt_count    = count_q;
    assign overflow_err = overflow_q;
    assign hold_out     = (count_q >= CNT_W'(DEPTH - HOLD_MARGIN));

    // Packet storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= ocp_rd_resp_pkt;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_en && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !wr_en) begin
                count_q <= count_q - 1'b1;
            end
            if (ocp_rd_resp_pkt_vld && !wr_en) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Replay FSM state and beat counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next state: start on a non-empty FIFO, advance per handshake, chain packets without gaps.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StSend;
                    beat_d  = '0;
                end
            end
            StSend: begin
                if (handshake) begin
                    if (!last_beat) begin
                        beat_d = beat_q + 4'd1;
                    end else begin
                        beat_d = '0;
                        if (!(count_q > CNT_W'(1) || wr_en)) begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                beat_d  = '0;
            end
        endcase
    end

endmodule
